// File: rtl/frame_pkg.sv
// Shared definitions for the frame capture path:
// FSM encoding, bus widths and default window size.
package frame_pkg;

  localparam int ADDR_W    = 22;
  localparam int PIX_W     = 24;
  localparam int CNT_W     = 16;
  localparam int H_PIX_DEF = 320;
  localparam int V_PIX_DEF = 240;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WAIT_VS = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

endpackage

// File: rtl/sync_edge_det.sv
// Registered falling-edge detection for the source
// vertical sync (active-low) and data-enable.
module sync_edge_det (
  input  logic clk_i,
  input  logic rst_i,
  input  logic vs_i,
  input  logic de_i,
  output logic vs_fall_o,
  output logic de_fall_o
);

  logic vs_q;
  logic de_q;

  // vs idles high so a reset never looks like a sync edge
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vs_q <= 1'b1;
      de_q <= 1'b0;
    end else begin
      vs_q <= vs_i;
      de_q <= de_i;
    end
  end

  assign vs_fall_o = vs_q & ~vs_i;
  assign de_fall_o = de_q & ~de_i;

endmodule

// File: rtl/frame_writer.sv
// Captures one windowed frame of a DE/VS video stream
// into a linear frame buffer, one write per stored pixel.
module frame_writer
  import frame_pkg::*;
#(
  parameter int H_PIX = H_PIX_DEF,
  parameter int V_PIX = V_PIX_DEF,
  parameter int X_OFF = 0,
  parameter int Y_OFF = 0
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iStart,
  input  logic              iVS,
  input  logic              iDE,
  input  logic [7:0]        iRed,
  input  logic [7:0]        iGreen,
  input  logic [7:0]        iBlue,
  output logic [ADDR_W-1:0] oAddress,
  output logic [PIX_W-1:0]  oData,
  output logic              oWren,
  output logic              oBusy,
  output logic              oFrame_Done,
  output logic              oAbort
);

  localparam logic [CNT_W-1:0] X_LO = CNT_W'(X_OFF);
  localparam logic [CNT_W-1:0] Y_LO = CNT_W'(Y_OFF);
  localparam logic [CNT_W-1:0] X_N  = CNT_W'(H_PIX);
  localparam logic [CNT_W-1:0] Y_N  = CNT_W'(V_PIX);
  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(H_PIX * V_PIX - 1);

  logic              vs_fall;
  logic              de_fall;
  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  x_q, x_d;
  logic [CNT_W-1:0]  y_q, y_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [PIX_W-1:0]  data_q, data_d;
  logic              wren_q, wren_d;
  logic              abort_q, abort_d;
  logic              done_q;
  logic              in_win;

  sync_edge_det u_edge (
    .clk_i     (iCLK),
    .rst_i     (iRST),
    .vs_i      (iVS),
    .de_i      (iDE),
    .vs_fall_o (vs_fall),
    .de_fall_o (de_fall)
  );

  // offset-subtract wraps below the window, so one compare per axis
  assign in_win = iDE
               && ((x_q - X_LO) < X_N)
               && ((y_q - Y_LO) < Y_N);

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wren_d  = 1'b0;
    abort_d = 1'b0;

    if (iDE && (x_q != '1)) x_d = x_q + 1'b1;
    if (de_fall) begin
      x_d = '0;
      if (y_q != '1) y_d = y_q + 1'b1;
    end
    if (vs_fall) begin
      x_d = '0;
      y_d = '0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (iStart) state_d = S_WAIT_VS;
      end
      S_WAIT_VS: begin
        if (vs_fall) begin
          state_d = S_CAPTURE;
          cnt_d   = '0;
        end
      end
      S_CAPTURE: begin
        if (vs_fall) begin
          state_d = S_WAIT_VS;
          abort_d = 1'b1;
        end else if (in_win) begin
          wren_d = 1'b1;
          addr_d = cnt_q;
          data_d = {iRed, iGreen, iBlue};
          if (cnt_q == LAST) state_d = S_DONE;
          else cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wren_q  <= 1'b0;
      abort_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wren_q  <= wren_d;
      abort_q <= abort_d;
      done_q  <= (state_q == S_DONE);
    end
  end

  assign oAddress    = addr_q;
  assign oData       = data_q;
  assign oWren       = wren_q;
  assign oAbort      = abort_q;
  assign oFrame_Done = done_q;
  assign oBusy       = (state_q == S_WAIT_VS)
                    || (state_q == S_CAPTURE);

endmodule

// File: tb/tb_frame_writer.sv
// Directed bench: a 4x3 window at offset (0,0) and one
// at offset (2,1), driven by the same source stream.
module tb_frame_writer;

  logic clk = 1'b0;
  logic rst, start, vs, de;
  logic [7:0] r, g, b;

  logic [21:0] a0, a1;
  logic [23:0] d0, d1;
  logic w0, w1, bz0, bz1, fd0, fd1, ab0, ab1;

  always #5 clk = ~clk;

  frame_writer #(.H_PIX(4), .V_PIX(3),
                 .X_OFF(0), .Y_OFF(0)) dut0 (
    .iCLK(clk), .iRST(rst), .iStart(start),
    .iVS(vs), .iDE(de),
    .iRed(r), .iGreen(g), .iBlue(b),
    .oAddress(a0), .oData(d0), .oWren(w0),
    .oBusy(bz0), .oFrame_Done(fd0), .oAbort(ab0)
  );

  frame_writer #(.H_PIX(4), .V_PIX(3),
                 .X_OFF(2), .Y_OFF(1)) dut1 (
    .iCLK(clk), .iRST(rst), .iStart(start),
    .iVS(vs), .iDE(de),
    .iRed(r), .iGreen(g), .iBlue(b),
    .oAddress(a1), .oData(d1), .oWren(w1),
    .oBusy(bz1), .oFrame_Done(fd1), .oAbort(ab1)
  );

  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;

  int          nw[2];
  logic [21:0] wa[2][64];
  logic [23:0] wd[2][64];
  int          wcyc[2][64];
  int          ndone[2];
  int          done_cyc[2];
  int          nab[2];
  int          busy_ab[2];

  typedef struct {
    int nl; int ll;
    int w0; int dn0; int pl0;
    int w1; int dn1; int pl1;
  } row_t;

  task automatic chk(input string nm, input int act,
                     input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  task automatic clear_logs();
    for (int i = 0; i < 2; i++) begin
      nw[i] = 0; ndone[i] = 0; done_cyc[i] = -1;
      nab[i] = 0; busy_ab[i] = -1;
    end
  endtask

  task automatic log1(input int i, input logic w,
                      input logic [21:0] a,
                      input logic [23:0] d,
                      input logic fd, input logic ab,
                      input logic bz);
    if (w) begin
      if (nw[i] < 64) begin
        wa[i][nw[i]] = a;
        wd[i][nw[i]] = d;
        wcyc[i][nw[i]] = cyc;
      end
      nw[i]++;
    end
    if (fd) begin
      ndone[i]++;
      done_cyc[i] = cyc;
    end
    if (ab) begin
      nab[i]++;
      busy_ab[i] = int'(bz);
    end
  endtask

  task automatic step(input logic s, input logic v,
                      input logic e, input logic [7:0] rr,
                      input logic [7:0] gg,
                      input logic [7:0] bb);
    start = s; vs = v; de = e;
    r = rr; g = gg; b = bb;
    @(negedge clk);
    log1(0, w0, a0, d0, fd0, ab0, bz0);
    log1(1, w1, a1, d1, fd1, ab1, bz1);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n, input logic v);
    repeat (n) step(1'b0, v, 1'b0, 8'h0, 8'h0, 8'h0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2, 1'b1);
    rst = 1'b0;
    idle(1, 1'b1);
    clear_logs();
  endtask

  task automatic line(input int y, input int n,
                      input int sl);
    for (int x = 0; x < n; x++)
      step((y == sl) && (x == 0), 1'b1, 1'b1,
           8'(x), 8'(y), 8'hC3);
  endtask

  task automatic vs_pulse();
    idle(2, 1'b1);
    idle(2, 1'b0);
    idle(1, 1'b1);
  endtask

  task automatic send_frame(input int nl, input int ll,
                            input int sl);
    vs_pulse();
    for (int y = 0; y < nl; y++) begin
      line(y, ll, sl);
      idle(3, 1'b1);
    end
    idle(3, 1'b1);
  endtask

  task automatic arm();
    step(1'b1, 1'b1, 1'b0, 8'h0, 8'h0, 8'h0);
  endtask

  task automatic check_frame(input int i, input int ew,
                             input int edn, input int xo,
                             input int yo, input int pl);
    int late;
    chk($sformatf("dut%0d_writes", i), nw[i], ew);
    chk($sformatf("dut%0d_done", i), ndone[i], edn);
    for (int k = 0; k < nw[i] && k < 64; k++) begin
      chk($sformatf("dut%0d_addr%0d", i, k),
          int'(wa[i][k]), k);
      chk($sformatf("dut%0d_data%0d", i, k),
          int'(wd[i][k]),
          int'({8'(xo + k % pl), 8'(yo + k / pl),
                8'hC3}));
    end
    if (edn != 0 && nw[i] > 0 && nw[i] <= 64) begin
      chk($sformatf("dut%0d_done_lat", i),
          done_cyc[i] - wcyc[i][nw[i]-1], 1);
      late = 0;
      for (int k = 0; k < nw[i]; k++)
        if (wcyc[i][k] > done_cyc[i]) late++;
      chk($sformatf("dut%0d_after_done", i), late, 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    row_t rows[3];
    rows[0] = '{3, 4, 12, 1, 4,  4, 0, 2};
    rows[1] = '{5, 8, 12, 1, 4, 12, 1, 4};
    rows[2] = '{10, 6, 12, 1, 4, 12, 1, 4};

    rst = 1'b1; start = 1'b0; vs = 1'b1; de = 1'b0;
    r = 8'h0; g = 8'h0; b = 8'h0;
    clear_logs();
    #1;
    chk("rst_addr", int'(a0), 0);
    chk("rst_data", int'(d0), 0);
    chk("rst_wren", int'(w0), 0);
    chk("rst_busy", int'(bz0), 0);
    chk("rst_done", int'(fd0), 0);
    chk("rst_abort", int'(ab0), 0);
    @(posedge clk);
    #1;

    for (int t = 0; t < 3; t++) begin
      do_reset();
      arm();
      send_frame(rows[t].nl, rows[t].ll, -1);
      check_frame(0, rows[t].w0, rows[t].dn0,
                  0, 0, rows[t].pl0);
      check_frame(1, rows[t].w1, rows[t].dn1,
                  2, 1, rows[t].pl1);
      chk($sformatf("row%0d_busy0", t), int'(bz0),
          rows[t].dn0 != 0 ? 0 : 1);
      chk($sformatf("row%0d_busy1", t), int'(bz1),
          rows[t].dn1 != 0 ? 0 : 1);
    end

    // abort after five writes, then a clean retry
    do_reset();
    arm();
    vs_pulse();
    line(0, 4, -1);
    idle(3, 1'b1);
    line(1, 1, -1);
    idle(2, 1'b1);
    idle(4, 1'b0);
    chk("abort_writes", nw[0], 5);
    chk("abort_pulses", nab[0], 1);
    chk("abort_busy", busy_ab[0], 1);
    chk("abort_busy_after", int'(bz0), 1);
    clear_logs();
    send_frame(3, 4, -1);
    check_frame(0, 12, 1, 0, 0, 4);
    chk("retry_abort", nab[0], 0);

    // reset after seven writes
    do_reset();
    arm();
    vs_pulse();
    line(0, 4, -1);
    idle(3, 1'b1);
    line(1, 3, -1);
    de = 1'b0;
    chk("pre_rst_writes", nw[0], 6);
    chk("pre_rst_wren", int'(w0), 1);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_addr", int'(a0), 0);
    chk("mid_rst_data", int'(d0), 0);
    chk("mid_rst_wren", int'(w0), 0);
    chk("mid_rst_busy", int'(bz0), 0);
    chk("mid_rst_done", int'(fd0), 0);
    chk("mid_rst_abort", int'(ab0), 0);
    @(posedge clk);
    #1;
    idle(2, 1'b1);
    chk("rst_no_abort", nab[0], 0);
    rst = 1'b0;
    idle(1, 1'b1);
    clear_logs();
    send_frame(3, 4, -1);
    chk("noarm_writes", nw[0], 0);
    chk("noarm_busy", int'(bz0), 0);
    arm();
    send_frame(3, 4, -1);
    check_frame(0, 12, 1, 0, 0, 4);

    // iStart during capture has no effect
    do_reset();
    arm();
    send_frame(10, 4, 1);
    check_frame(0, 12, 1, 0, 0, 4);
    clear_logs();
    send_frame(3, 4, -1);
    chk("start_ignored_writes", nw[0], 0);
    chk("start_ignored_busy", int'(bz0), 0);

    $display("Result: errors=%0d of %0d checks",
             nerr, nchk);
    $finish;
  end

endmodule
